// File: rtl/mem_req_arbiter.sv
// Arbitrates the byte-serial memory engine among fetch, load and store requesters.
// Define MEM_ARB_AGING_EN to enable the fetch starvation counter (aging).
module mem_req_arbiter #(
  parameter int unsigned STARVE_LIM = 8,
  parameter logic [1:0]  IO_HI      = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_len,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_len,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        eng_start,
  output logic        eng_wr,
  output logic [31:0] eng_addr,
  output logic [1:0]  eng_len,
  output logic [31:0] eng_wdata,
  input  logic        eng_done,
  input  logic [31:0] eng_rdata,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY_IF = 3'd1,
    S_BUSY_LD = 3'd2,
    S_BUSY_ST = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_st_ok, w_ld_ok, w_if_ok;
  logic   w_gnt_st, w_gnt_ld, w_gnt_if;
  logic   w_fetch_first;

  // A requester whose done is showing is masked; flush blocks new reads only.
  assign w_st_ok = st_req && !st_done && !((st_addr[17:16] == IO_HI) && io_buffer_full);
  assign w_ld_ok = ld_req && !ld_done && !clr;
  assign w_if_ok = if_req && !if_done && !clr;

`ifdef MEM_ARB_AGING_EN
  logic [3:0] r_starve;

  // >= keeps fetch promoted if a flush-blocked cycle let the count run past the limit.
  assign w_fetch_first = (r_starve >= 4'(STARVE_LIM));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= 4'd0;
    end else if (rdy) begin
      if (!if_req || w_gnt_if) begin
        r_starve <= 4'd0;
      end else if ((w_gnt_st || w_gnt_ld) && (r_starve != 4'hF)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end
`else
  assign w_fetch_first = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_st    = 1'b0;
    w_gnt_ld    = 1'b0;
    w_gnt_if    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fetch_first && w_if_ok) begin
          w_gnt_if    = 1'b1;
          w_state_nxt = S_BUSY_IF;
        end else if (w_st_ok) begin
          w_gnt_st    = 1'b1;
          w_state_nxt = S_BUSY_ST;
        end else if (w_ld_ok) begin
          w_gnt_ld    = 1'b1;
          w_state_nxt = S_BUSY_LD;
        end else if (w_if_ok) begin
          w_gnt_if    = 1'b1;
          w_state_nxt = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_LD: begin
        if (eng_done)  w_state_nxt = S_IDLE;
        else if (clr)  w_state_nxt = S_DRAIN;
      end
      S_BUSY_ST, S_DRAIN: begin
        if (eng_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      eng_start <= 1'b0;
      eng_wr    <= 1'b0;
      eng_addr  <= 32'h0;
      eng_len   <= 2'b00;
      eng_wdata <= 32'h0;
      if_done   <= 1'b0;
      ld_done   <= 1'b0;
      st_done   <= 1'b0;
      if_data   <= 32'h0;
      ld_data   <= 32'h0;
    end else if (rdy) begin
      r_state   <= w_state_nxt;
      eng_start <= 1'b0;
      if_done   <= 1'b0;
      ld_done   <= 1'b0;
      st_done   <= 1'b0;
      if (w_gnt_st) begin
        eng_start <= 1'b1;
        eng_wr    <= 1'b1;
        eng_addr  <= st_addr;
        eng_len   <= st_len;
        eng_wdata <= st_data;
      end else if (w_gnt_ld) begin
        eng_start <= 1'b1;
        eng_wr    <= 1'b0;
        eng_addr  <= ld_addr;
        eng_len   <= ld_len;
        eng_wdata <= 32'h0;
      end else if (w_gnt_if) begin
        eng_start <= 1'b1;
        eng_wr    <= 1'b0;
        eng_addr  <= if_addr;
        eng_len   <= 2'b10;
        eng_wdata <= 32'h0;
      end
      // A flush landing on the completion cycle cancels the read's done.
      if (eng_done) begin
        case (r_state)
          S_BUSY_IF: if (!clr) begin
            if_done <= 1'b1;
            if_data <= eng_rdata;
          end
          S_BUSY_LD: if (!clr) begin
            ld_done <= 1'b1;
            ld_data <= eng_rdata;
          end
          S_BUSY_ST: st_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: directed scenarios, engine model, queue-based monitor.
module tb_mem_req_arbiter;
  logic        clk, rst, rdy, clr, io_buffer_full;
  logic        if_req, ld_req, st_req;
  logic [31:0] if_addr, ld_addr, st_addr, st_data;
  logic [1:0]  ld_len, st_len;
  logic        if_done, ld_done, st_done;
  logic [31:0] if_data, ld_data;
  logic        eng_start, eng_wr, eng_done;
  logic [31:0] eng_addr, eng_wdata, eng_rdata;
  logic [1:0]  eng_len;
  logic [2:0]  dbg_state;

  // Valid/ready: a command is accepted by the engine on an edge where eng_start && rdy;
  // a completion is reported by a one-cycle x_done taken on an edge where rdy is high.
  logic [66:0] exp_cmd_q[$];   // {wr, len, addr, wdata (0 for reads)}
  logic [34:0] exp_done_q[$];  // {if, ld, st one-hot, data}

  int n_cmp = 0;
  int n_bad = 0;
  int n_starts = 0;
  int eng_lat = 3;

  mem_req_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_done(st_done),
    .eng_start(eng_start), .eng_wr(eng_wr), .eng_addr(eng_addr), .eng_len(eng_len),
    .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_rdata(eng_rdata), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic wr, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd);
    exp_cmd_q.push_back({wr, len, a, (wr ? wd : 32'h0)});
  endtask

  task automatic push_done(input logic [2:0] who, input logic [31:0] d);
    exp_done_q.push_back({who, d});
  endtask

  function automatic logic [31:0] eng_model(input logic [31:0] a, input logic [1:0] len);
    logic [31:0] raw;
    raw = (a == 32'h1000) ? 32'hDEADBEEF : {a[7:0] ^ 8'hC3, 8'hB7, 8'h5E, a[7:0] ^ 8'h81};
    case (len)
      2'b00:   return {24'h0, raw[7:0]};
      2'b01:   return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // ---------------- engine model ----------------
  initial begin : engine
    int  cnt;
    bit  busy;
    logic [31:0] a;
    logic [1:0]  l;
    cnt = 0; busy = 0; a = '0; l = '0;
    eng_done = 1'b0;
    eng_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        eng_done = 1'b0;
      end else if (rdy) begin
        eng_done = 1'b0;
        if (eng_start) begin
          busy = 1; cnt = eng_lat; a = eng_addr; l = eng_len;
        end else if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 0;
            eng_done = 1'b1;
            eng_rdata = eng_model(a, l);
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [66:0] e;
    logic [34:0] d;
    if (!rst && rdy) begin
      if (eng_start) begin
        n_starts++;
        if (exp_cmd_q.size() == 0) begin
          chk("unexpected_start", {eng_wr, eng_len, eng_addr, eng_wdata}, 67'h0);
        end else begin
          e = exp_cmd_q.pop_front();
          chk("eng_cmd", {eng_wr, eng_len, eng_addr, (eng_wr ? eng_wdata : 32'h0)}, e);
        end
      end
      if (if_done || ld_done || st_done) begin
        d = {if_done, ld_done, st_done, (if_done ? if_data : (ld_done ? ld_data : 32'h0))};
        if (exp_done_q.size() == 0) chk("unexpected_done", {32'h0, d}, 67'h0);
        else chk("done_pulse", {32'h0, d}, {32'h0, exp_done_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int id, output int cyc);
    bit seen;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      case (id)
        0:       seen = if_done;
        1:       seen = ld_done;
        default: seen = st_done;
      endcase
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_done_%0d: got no done expected a done pulse", id);
    end
    case (id)
      0:       if_req = 1'b0;
      1:       ld_req = 1'b0;
      default: st_req = 1'b0;
    endcase
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(eng_start && rdy) && cyc < 400);
    if (cyc >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_start: got no eng_start expected one");
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    int cyc;
    int base;
    int seq[12];
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
    if_req = 0; ld_req = 0; st_req = 0;
    if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; ld_len = '0; st_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_state", dbg_state, 0);
    chk("rst_eng", {eng_start, eng_wr, eng_len, eng_addr, eng_wdata}, 67'h0);
    chk("rst_done", {if_done, ld_done, st_done, if_data, ld_data}, 67'h0);

    // Single fetch, N=5
    eng_lat = 5;
    if_addr = 32'h1000; if_req = 1'b1;
    push_cmd(0, 2'b10, 32'h1000, 0);
    push_done(3'b100, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_start_high", eng_start, 1);
    chk("t1_state", dbg_state, 1);
    @(negedge clk);
    chk("t1_start_low", eng_start, 0);
    wait_done(0, cyc);
    chk("t1_done_latency", cyc, 5);
    @(negedge clk);
    chk("t1_done_pulse_width", if_done, 0);
    chk("t1_data_hold", if_data, 32'hDEADBEEF);

    // Simultaneous store, load, fetch
    eng_lat = 3;
    st_addr = 32'h2000; st_len = 2'b10; st_data = 32'h11223344; st_req = 1'b1;
    ld_addr = 32'h2100; ld_len = 2'b01; ld_req = 1'b1;
    if_addr = 32'h2204; if_req = 1'b1;
    push_cmd(1, 2'b10, 32'h2000, 32'h11223344);
    push_cmd(0, 2'b01, 32'h2100, 0);
    push_cmd(0, 2'b10, 32'h2204, 0);
    push_done(3'b001, 32'h0);
    push_done(3'b010, 32'h0000_5E81);
    push_done(3'b100, 32'hC7B75E85);
    fork
      begin int c0; wait_done(2, c0); end
      begin int c1; wait_done(1, c1); end
      begin int c2; wait_done(0, c2); end
    join

    // Flush during load: DRAIN, no ld_done, fetch waits for the engine
    eng_lat = 6;
    @(negedge clk);
    ld_addr = 32'h3000; ld_len = 2'b00; ld_req = 1'b1;
    push_cmd(0, 2'b00, 32'h3000, 0);
    wait_start(cyc);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1; ld_req = 1'b0;
    if_addr = 32'h3104; if_req = 1'b1;
    push_cmd(0, 2'b10, 32'h3104, 0);
    push_done(3'b100, 32'hC7B75E85);
    @(negedge clk);
    clr = 1'b0;
    chk("t3_drain", dbg_state, 4);
    wait_start(cyc);
    chk("t3_fetch_after_drain", cyc, 5);
    wait_done(0, cyc);

    // Flush during store: store still completes
    eng_lat = 4;
    @(negedge clk);
    st_addr = 32'h3200; st_len = 2'b10; st_data = 32'hA1B2C3D4; st_req = 1'b1;
    push_cmd(1, 2'b10, 32'h3200, 32'hA1B2C3D4);
    push_done(3'b001, 32'h0);
    wait_start(cyc);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t3_store_ignores_clr", dbg_state, 3);
    wait_done(2, cyc);

    // clr coinciding with eng_done in BUSY_IF: back to IDLE, no done
    eng_lat = 3;
    @(negedge clk);
    if_addr = 32'h3300; if_req = 1'b1;
    push_cmd(0, 2'b10, 32'h3300, 0);
    wait_start(cyc);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; if_req = 1'b0;
    chk("t3_coincide_state", dbg_state, 0);
    chk("t3_coincide_no_done", if_done, 0);

    // IO back-pressure: load passes the held IO store
    eng_lat = 2;
    @(negedge clk);
    io_buffer_full = 1'b1;
    st_addr = 32'h0003_0000; st_len = 2'b00; st_data = 32'h5A; st_req = 1'b1;
    ld_addr = 32'h4000; ld_len = 2'b10; ld_req = 1'b1;
    push_cmd(0, 2'b10, 32'h4000, 0);
    push_done(3'b010, 32'hC3B75E81);
    wait_done(1, cyc);
    repeat (4) @(negedge clk);
    chk("t4_store_held", dbg_state, 0);
    push_cmd(1, 2'b00, 32'h0003_0000, 32'h5A);
    push_done(3'b001, 32'h0);
    io_buffer_full = 1'b0;
    wait_done(2, cyc);

    // Starvation: store and load held continuously with fetch pending
    eng_lat = 1;
    for (int i = 0; i < 12; i++) seq[i] = i % 2;
`ifdef MEM_ARB_AGING_EN
    seq[8] = 2; seq[9] = 0; seq[10] = 1; seq[11] = 0;
`endif
    for (int i = 0; i < 12; i++) begin
      case (seq[i])
        0: begin push_cmd(1, 2'b10, 32'h5200, 32'h0BADF00D); push_done(3'b001, 32'h0); end
        1: begin push_cmd(0, 2'b01, 32'h5000, 0); push_done(3'b010, 32'h0000_5E81); end
        default: begin push_cmd(0, 2'b10, 32'h5104, 0); push_done(3'b100, 32'hC7B75E85); end
      endcase
    end
    @(negedge clk);
    base = n_starts;
    st_addr = 32'h5200; st_len = 2'b10; st_data = 32'h0BADF00D; st_req = 1'b1;
    ld_addr = 32'h5000; ld_len = 2'b01; ld_req = 1'b1;
    if_addr = 32'h5104; if_req = 1'b1;
    cyc = 0;
    while (n_starts < base + 12 && cyc < 400) begin
      @(negedge clk);
      #1 cyc++;
    end
    st_req = 1'b0; ld_req = 1'b0; if_req = 1'b0;
    chk("t5_grant_count", n_starts - base, 12);
    repeat (6) @(negedge clk);

    // Reset in the middle of a load
    eng_lat = 8;
    ld_addr = 32'h6000; ld_len = 2'b01; ld_req = 1'b1;
    push_cmd(0, 2'b01, 32'h6000, 0);
    wait_start(cyc);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1; ld_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_state", dbg_state, 0);
    chk("t6_rst_eng", {eng_start, eng_wr, eng_len, eng_addr, eng_wdata}, 67'h0);
    chk("t6_rst_done", {if_done, ld_done, st_done, if_data, ld_data}, 67'h0);

    // rdy=0 for 3 cycles while eng_start is high
    eng_lat = 2;
    if_addr = 32'h7008; if_req = 1'b1;
    push_cmd(0, 2'b10, 32'h7008, 0);
    push_done(3'b100, 32'hCBB75E89);
    @(posedge clk);
    #1 rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t7_stall_start", eng_start, 1);
      chk("t7_stall_state", dbg_state, 1);
    end
    @(posedge clk);
    #1 rdy = 1'b1;
    wait_done(0, cyc);

    repeat (5) @(negedge clk);
    chk("cmd_q_empty", exp_cmd_q.size(), 0);
    chk("done_q_empty", exp_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
